// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor: permutes S-RAM, XORs keystream with ROM.
// Ports: start/busy/done/invalid control, S-RAM, encrypted ROM and decrypted RAM buses.
module rc4_prga_decrypt #(
  parameter int MSG_LEN     = 32,
  parameter int MSG_AW      = 5,
  parameter int CHECK_ASCII = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              invalid,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] out_addr,
  output logic [7:0]        out_wdata,
  output logic              out_wren
);

  localparam logic [MSG_AW-1:0] K_LAST =
    MSG_AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_I,
    S_WT_I,
    S_RD_J,
    S_WT_J,
    S_WR_I,
    S_WR_J,
    S_RD_F,
    S_WT_F,
    S_WR_OUT,
    S_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [7:0]        i;
  logic [7:0]        j;
  logic [MSG_AW-1:0] k;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [7:0]        p;
  logic              done_q;
  logic              invalid_q;
  logic              legal;
  logic              bad;
  logic              last;

  // Accepted plaintext alphabet: space and lowercase letters.
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (p == 8'h20):                  legal = 1'b1;
      (p >= 8'h61 && p <= 8'h7a):    legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
  end

  assign bad  = (CHECK_ASCII != 0) && !legal;
  assign last = (k == K_LAST);

  assign done    = done_q;
  assign invalid = invalid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    rom_addr  = '0;
    out_addr  = '0;
    out_wdata = '0;
    out_wren  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_RD_I;
      end
      S_RD_I: begin
        busy   = 1'b1;
        s_addr = i + 8'd1;
        nxt    = S_WT_I;
      end
      S_WT_I: begin
        busy = 1'b1;
        nxt  = S_RD_J;
      end
      S_RD_J: begin
        busy   = 1'b1;
        s_addr = j + si;
        nxt    = S_WT_J;
      end
      S_WT_J: begin
        busy = 1'b1;
        nxt  = S_WR_I;
      end
      S_WR_I: begin
        busy    = 1'b1;
        s_addr  = i;
        s_wdata = sj;
        s_wren  = 1'b1;
        nxt     = S_WR_J;
      end
      // When i == j this second write lands last,
      // leaving si in place: the swap is a no-op.
      S_WR_J: begin
        busy    = 1'b1;
        s_addr  = j;
        s_wdata = si;
        s_wren  = 1'b1;
        nxt     = S_RD_F;
      end
      S_RD_F: begin
        busy     = 1'b1;
        s_addr   = si + sj;
        rom_addr = k;
        nxt      = S_WT_F;
      end
      S_WT_F: begin
        busy = 1'b1;
        nxt  = S_WR_OUT;
      end
      S_WR_OUT: begin
        busy = 1'b1;
        if (bad) begin
          nxt = S_DONE;
        end else begin
          out_addr  = k;
          out_wdata = p;
          out_wren  = 1'b1;
          nxt       = last ? S_DONE : S_RD_I;
        end
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      p         <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            done_q    <= 1'b0;
            invalid_q <= 1'b0;
          end
        end
        S_RD_I: i  <= i + 8'd1;
        S_WT_I: si <= s_q;
        S_RD_J: j  <= j + si;
        S_WT_J: sj <= s_q;
        S_WT_F: p  <= s_q ^ rom_q;
        S_WR_OUT: begin
          if (bad) begin
            invalid_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (last) begin
            done_q <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: two instances (ASCII check off/on)
// with behavioural S-RAM, ROM and output RAM.
`timescale 1ns/1ps
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, load_a, load_b;

  logic       a_busy, a_done, a_invalid, a_s_wren, a_out_wren;
  logic [7:0] a_s_addr, a_s_wdata, a_s_q, a_rom_q, a_out_wdata;
  logic [4:0] a_rom_addr, a_out_addr;
  logic       b_busy, b_done, b_invalid, b_s_wren, b_out_wren;
  logic [7:0] b_s_addr, b_s_wdata, b_s_q, b_rom_q, b_out_wdata;
  logic [4:0] b_rom_addr, b_out_addr;

  logic [7:0] s_init [256];
  logic [7:0] sa [256];
  logic [7:0] sb [256];
  logic [7:0] rom_a [32];
  logic [7:0] rom_b [32];
  logic [7:0] oa [32];
  logic [7:0] ob [32];
  logic [7:0] ks [32];
  logic [7:0] pt [32];

  int n_chk = 0;
  int n_fail = 0;

  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5), .CHECK_ASCII(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .busy(a_busy), .done(a_done), .invalid(a_invalid),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wren(a_s_wren),
    .s_q(a_s_q), .rom_addr(a_rom_addr), .rom_q(a_rom_q),
    .out_addr(a_out_addr), .out_wdata(a_out_wdata),
    .out_wren(a_out_wren)
  );

  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5), .CHECK_ASCII(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .busy(b_busy), .done(b_done), .invalid(b_invalid),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wren(b_s_wren),
    .s_q(b_s_q), .rom_addr(b_rom_addr), .rom_q(b_rom_q),
    .out_addr(b_out_addr), .out_wdata(b_out_wdata),
    .out_wren(b_out_wren)
  );

  always @(posedge clk) begin
    if (load_a) begin
      sa <= s_init;
      for (int n = 0; n < 32; n++) oa[n] <= 8'hee;
    end else begin
      a_s_q   <= sa[a_s_addr];
      a_rom_q <= rom_a[a_rom_addr];
      if (a_s_wren) sa[a_s_addr] <= a_s_wdata;
      if (a_out_wren) oa[a_out_addr] <= a_out_wdata;
    end
  end

  always @(posedge clk) begin
    if (load_b) begin
      sb <= s_init;
      for (int n = 0; n < 32; n++) ob[n] <= 8'hee;
    end else begin
      b_s_q   <= sb[b_s_addr];
      b_rom_q <= rom_b[b_rom_addr];
      if (b_s_wren) sb[b_s_addr] <= b_s_wdata;
      if (b_out_wren) ob[b_out_addr] <= b_out_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] smem(input bit sel, input int a);
    return sel ? sb[a] : sa[a];
  endfunction

  task automatic compute_ksa();
    logic [7:0] kb [3];
    logic [7:0] jj, t;
    kb[0] = 8'h00; kb[1] = 8'h02; kb[2] = 8'h49;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s_init[n] + kb[n % 3];
      t = s_init[n]; s_init[n] = s_init[jj]; s_init[jj] = t;
    end
  endtask

  task automatic gen_ks();
    logic [7:0] s [256];
    logic [7:0] ii, jj, t, f;
    s = s_init;
    ii = 8'h00; jj = 8'h00;
    for (int n = 0; n < 32; n++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      f = s[ii] + s[jj];
      ks[n] = s[f];
    end
  endtask

  task automatic load(input bit sel);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    @(posedge clk); #1;
    load_a = 1'b0; load_b = 1'b0;
  endtask

  task automatic run(input bit sel, input int pulse_at,
                     input int rst_at, output int busy_n,
                     output int done_at, output int ow_n,
                     output int sw_n, output logic [7:0] snap2,
                     output logic [7:0] snap3);
    logic bz, dn, sw, ow;
    logic [4:0] oad;
    logic [38:0] outs;
    bit ended;
    busy_n = 0; done_at = -1; ow_n = 0; sw_n = 0;
    snap2 = 8'h00; snap3 = 8'h00; ended = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        outs = sel ?
          {b_busy, b_done, b_invalid, b_s_wren, b_out_wren,
           b_s_addr, b_s_wdata, b_rom_addr, b_out_addr, b_out_wdata} :
          {a_busy, a_done, a_invalid, a_s_wren, a_out_wren,
           a_s_addr, a_s_wdata, a_rom_addr, a_out_addr, a_out_wdata};
        chk("reset_mid_run_outputs", 64'(outs), 64'h0);
        ended = 1'b1;
        break;
      end
      bz  = sel ? b_busy : a_busy;
      dn  = sel ? b_done : a_done;
      sw  = sel ? b_s_wren : a_s_wren;
      ow  = sel ? b_out_wren : a_out_wren;
      oad = sel ? b_out_addr : a_out_addr;
      if (dn) begin
        done_at = cyc;
        ended = 1'b1;
        break;
      end
      if (bz) busy_n++;
      if (sw) sw_n++;
      if (ow) begin
        ow_n++;
        if (oad == 5'd1) begin
          snap2 = smem(sel, 2);
          snap3 = smem(sel, 3);
        end
      end
      if (sel) start_b = (cyc == pulse_at);
      else start_a = (cyc == pulse_at);
      @(posedge clk); #1;
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("run_terminated", 64'(ended), 64'h1);
  endtask

  typedef struct {
    int         addr;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t t1 [4];
    int bn, da, own, swn;
    logic [7:0] s2, s3;
    string msg;

    t1[0] = '{0, 8'h02};
    t1[1] = '{1, 8'h05};
    t1[2] = '{2, 8'h07};
    t1[3] = '{3, 8'h0d};

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    load_a = 1'b0; load_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 64'({a_busy, a_done, a_invalid, a_s_wren,
                        a_out_wren, a_s_addr, a_out_addr}), 64'h0);
    chk("reset_b", 64'({b_busy, b_done, b_invalid, b_s_wren,
                        b_out_wren, b_s_addr, b_out_addr}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity S, zero ciphertext: output is raw keystream.
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < 32; n++) rom_a[n] = 8'h00;
    load(1'b0);
    run(1'b0, -1, -1, bn, da, own, swn, s2, s3);
    for (int v = 0; v < 4; v++)
      chk($sformatf("ident_out%0d", t1[v].addr),
          64'(oa[t1[v].addr]), 64'(t1[v].exp));
    chk("ident_S2_after_byte1", 64'(s2), 64'h3);
    chk("ident_S3_after_byte1", 64'(s3), 64'h2);

    // Key-schedule S with key 00_02_49 and lowercase plaintext.
    compute_ksa();
    gen_ks();
    msg = "the quick brown fox jumps over a";
    for (int n = 0; n < 32; n++) begin
      pt[n] = msg[n];
      rom_a[n] = pt[n] ^ ks[n];
    end
    load(1'b0);
    run(1'b0, -1, -1, bn, da, own, swn, s2, s3);
    for (int n = 0; n < 32; n++)
      chk($sformatf("key_out%0d", n), 64'(oa[n]), 64'(pt[n]));
    chk("key_done", 64'(a_done), 64'h1);
    chk("key_invalid", 64'(a_invalid), 64'h0);
    chk("busy_cycles", 64'(bn), 64'd288);
    chk("done_cycle", 64'(da), 64'd289);
    chk("out_wren_pulses", 64'(own), 64'd32);
    chk("s_wren_pulses", 64'(swn), 64'd64);

    // Start pulsed mid-run must be ignored.
    load(1'b0);
    run(1'b0, 50, -1, bn, da, own, swn, s2, s3);
    for (int n = 0; n < 32; n++)
      chk($sformatf("pulse_out%0d", n), 64'(oa[n]), 64'(pt[n]));
    chk("pulse_done_cycle", 64'(da), 64'd289);

    // ASCII check: byte 4 decrypts to 'A'.
    for (int n = 0; n < 32; n++)
      rom_b[n] = (n == 4 ? 8'h41 : pt[n]) ^ ks[n];
    load(1'b1);
    run(1'b1, -1, -1, bn, da, own, swn, s2, s3);
    for (int n = 0; n < 4; n++)
      chk($sformatf("ascii_out%0d", n), 64'(ob[n]), 64'(pt[n]));
    chk("ascii_no_write_k4", 64'(ob[4]), 64'hee);
    chk("ascii_writes", 64'(own), 64'd4);
    chk("ascii_invalid", 64'(b_invalid), 64'h1);
    chk("ascii_done", 64'(b_done), 64'h1);
    chk("ascii_done_cycle", 64'(da), 64'd46);

    // Reset mid-run, then rerun from a fresh key schedule.
    load(1'b0);
    run(1'b0, -1, 100, bn, da, own, swn, s2, s3);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 64'({a_busy, a_done, a_invalid}), 64'h0);
    compute_ksa();
    load(1'b0);
    run(1'b0, -1, -1, bn, da, own, swn, s2, s3);
    for (int n = 0; n < 32; n++)
      chk($sformatf("rerun_out%0d", n), 64'(oa[n]), 64'(pt[n]));
    chk("rerun_done", 64'(a_done), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
